imem_responder: RTL and testbench

Instruction-memory responder: the memory side of the fetch interface driven by the CPU control FSM's `pc_rden` strobe. It accepts a read request on the rising edge of `rden`, waits a configurable number of wait states, then presents the instruction word with a one-cycle `rvalid` pulse. A separate load port writes program words into the backing array.

---
 rtl/imem_responder_pkg.sv | 20 ++
 rtl/imem_array.sv | 35 +++
 rtl/imem_responder.sv | 140 ++++++++++++++
 tb/tb_imem_responder.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: FSM encoding,
// wait-state limit and the alignment helper used by the optional check.
package imem_responder_pkg;

  // The wait counter is 4 bits wide, so WAIT_CYCLES is limited to 0..15.
  localparam int unsigned IMEM_WAIT_MAX = 15;
  localparam int unsigned IMEM_CNT_W    = 4;

  typedef enum logic [1:0] {
    ImemStIdle = 2'd0,
    ImemStWait = 2'd1,
    ImemStResp = 2'd2
  } imem_state_e;

  // True when the byte-offset bits of an address are non-zero.
  function automatic logic imem_misaligned(input logic [1:0] byte_off);
    return byte_off != 2'b00;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Word RAM behind the responder: synchronous write, synchronous read with a
// held output register (read-before-write on a same-address collision).
// Kept as its own module so a vendor block RAM can replace it.
module imem_array
  import imem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [31:0]           rdata
);

  localparam int unsigned Words = 1 << DEPTH_LOG2;

  logic [31:0] mem [Words];
  logic [31:0] rdata_q;

  // Write port and registered read port; the read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder for the CPU fetch path. A rising edge on rden
// starts a fetch; after WAIT_CYCLES wait states the word is presented with a
// one-cycle rvalid pulse and then held on rdata until the next response.
// Optional feature: define IMEM_RESPONDER_ALIGN_CHECK_EN to flag misaligned
// fetches (misalign_err, rdata forced to 0) and drop misaligned load writes.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rden,
  input  logic [31:0] addr,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        busy,
  input  logic        ld_wren,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
`ifdef IMEM_RESPONDER_ALIGN_CHECK_EN
  ,
  output logic        misalign_err
`endif
);

  localparam int unsigned            AddrW    = DEPTH_LOG2 + 2;
  localparam logic [IMEM_CNT_W-1:0]  WaitInit = IMEM_CNT_W'(WAIT_CYCLES);

  imem_state_e             state_q, state_d;
  logic [IMEM_CNT_W-1:0]   cnt_q, cnt_d;
  logic [AddrW-1:0]        addr_q, addr_d;
  logic                    rden_q;
  logic [31:0]             rdata_q;

  logic                    req;
  logic                    ram_re;
  logic                    ram_we;
  logic [DEPTH_LOG2-1:0]   ram_raddr;
  logic [31:0]             ram_rdata;
  logic [31:0]             rdata_resp;
  logic                    resp_misaligned;

  assign req = rden & ~rden_q;

  // Next-state logic; the RAM read is issued on the edge that enters RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    ram_re  = 1'b0;
    unique case (state_q)
      ImemStIdle: begin
        if (req) begin
          addr_d = addr[AddrW-1:0];
          if (WaitInit == '0) begin
            state_d = ImemStResp;
            ram_re  = 1'b1;
          end else begin
            state_d = ImemStWait;
            cnt_d   = WaitInit;
          end
        end
      end
      ImemStWait: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= IMEM_CNT_W'(1)) begin
          state_d = ImemStResp;
          ram_re  = 1'b1;
        end
      end
      ImemStResp: begin
        state_d = ImemStIdle;
      end
      default: begin
        state_d = ImemStIdle;
      end
    endcase
  end

  // Zero-wait fetches read straight from the port; otherwise from the latch.
  assign ram_raddr = (state_q == ImemStIdle) ? addr[AddrW-1:2] : addr_q[AddrW-1:2];

`ifdef IMEM_RESPONDER_ALIGN_CHECK_EN
  assign ram_we          = ld_wren & ~imem_misaligned(ld_addr[1:0]);
  assign resp_misaligned = imem_misaligned(addr_q[1:0]);
  assign misalign_err    = (state_q == ImemStResp) & resp_misaligned;
`else
  assign ram_we          = ld_wren;
  assign resp_misaligned = 1'b0;
`endif

  imem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ld_addr[AddrW-1:2]),
    .wdata(ld_data),
    .re   (ram_re),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  assign rdata_resp = resp_misaligned ? 32'h0 : ram_rdata;

  // State, counter, request-edge detector, address latch and rdata hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ImemStIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      rden_q  <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rden_q  <= rden;
      if (state_q == ImemStResp) begin
        rdata_q <= rdata_resp;
      end
    end
  end

  // Present the fresh word in the RESP cycle, the held word otherwise.
  assign rdata  = (state_q == ImemStResp) ? rdata_resp : rdata_q;
  assign rvalid = (state_q == ImemStResp);
  assign busy   = (state_q != ImemStIdle);

  // Address bits above the array size wrap; byte offsets are ignored here.
  logic unused_bits;
`ifdef IMEM_RESPONDER_ALIGN_CHECK_EN
  assign unused_bits = ^{addr[31:AddrW], ld_addr[31:AddrW]};
`else
  assign unused_bits = ^{addr[31:AddrW], ld_addr[31:AddrW], ld_addr[1:0], addr_q[1:0]};
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: one instance with zero wait states, one with
// three, sharing all inputs, checked every cycle against a cycle-indexed
// reference model plus hand-computed literal expectations.
module tb_imem_responder;

  logic        clk;
  logic        reset;
  logic        rden;
  logic [31:0] addr;
  logic        ld_wren;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;

  logic [1:0]  rvalid_w;
  logic [1:0]  busy_w;
  logic [31:0] rdata_w [2];
`ifdef IMEM_RESPONDER_ALIGN_CHECK_EN
  logic [1:0]  err_w;
  localparam bit AlignOn = 1'b1;
`else
  localparam bit AlignOn = 1'b0;
`endif

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  imem_responder #(
    .DEPTH_LOG2 (10),
    .WAIT_CYCLES(0)
  ) u0 (
    .clk    (clk),
    .reset  (reset),
    .rden   (rden),
    .addr   (addr),
    .rdata  (rdata_w[0]),
    .rvalid (rvalid_w[0]),
    .busy   (busy_w[0]),
    .ld_wren(ld_wren),
    .ld_addr(ld_addr),
    .ld_data(ld_data)
`ifdef IMEM_RESPONDER_ALIGN_CHECK_EN
    ,
    .misalign_err(err_w[0])
`endif
  );

  imem_responder #(
    .DEPTH_LOG2 (10),
    .WAIT_CYCLES(3)
  ) u3 (
    .clk    (clk),
    .reset  (reset),
    .rden   (rden),
    .addr   (addr),
    .rdata  (rdata_w[1]),
    .rvalid (rvalid_w[1]),
    .busy   (busy_w[1]),
    .ld_wren(ld_wren),
    .ld_addr(ld_addr),
    .ld_data(ld_data)
`ifdef IMEM_RESPONDER_ALIGN_CHECK_EN
    ,
    .misalign_err(err_w[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Edge-indexed: a request accepted at edge k responds at edge k+W; the
  // responder is free again for a request at edge k+W+2 or later.
  int          cyc = 0;
  int          wc        [2] = '{0, 3};
  int          m_start   [2] = '{-10, -10};
  int          m_resp    [2] = '{-10, -10};
  logic [31:0] m_addr    [2];
  logic [31:0] m_rdata   [2] = '{32'h0, 32'h0};
  bit          m_rv      [2] = '{1'b0, 1'b0};
  bit          m_busy    [2] = '{1'b0, 1'b0};
  bit          m_err     [2] = '{1'b0, 1'b0};
  bit          rden_prev = 1'b0;
  logic [31:0] mem_m [int];

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'h3FF);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_m.exists(widx(a))) return mem_m[widx(a)];
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        m_start[d] = -10;
        m_resp[d]  = -10;
        m_rdata[d] = 32'h0;
        m_rv[d]    = 1'b0;
        m_busy[d]  = 1'b0;
        m_err[d]   = 1'b0;
      end
      rden_prev = 1'b0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (rden && !rden_prev && cyc >= m_resp[d] + 2) begin
          m_start[d] = cyc;
          m_resp[d]  = cyc + wc[d];
          m_addr[d]  = addr;
        end
        m_rv[d]   = (cyc == m_resp[d]);
        m_busy[d] = (cyc >= m_start[d]) && (cyc <= m_resp[d]);
        m_err[d]  = 1'b0;
        if (m_rv[d]) begin
          if (AlignOn && m_addr[d][1:0] != 2'b00) begin
            m_rdata[d] = 32'h0;
            m_err[d]   = 1'b1;
          end else begin
            m_rdata[d] = mem_rd(m_addr[d]);
          end
        end
      end
      rden_prev = rden;
    end
    if (ld_wren && !(AlignOn && ld_addr[1:0] != 2'b00)) mem_m[widx(ld_addr)] = ld_data;
  end

  // Per-cycle comparison of both instances against the model.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("c%0d_u%0d_rvalid", cyc, d), 32'(rvalid_w[d]), 32'(m_rv[d]));
        check($sformatf("c%0d_u%0d_busy", cyc, d), 32'(busy_w[d]), 32'(m_busy[d]));
        check($sformatf("c%0d_u%0d_rdata", cyc, d), rdata_w[d], m_rdata[d]);
`ifdef IMEM_RESPONDER_ALIGN_CHECK_EN
        check($sformatf("c%0d_u%0d_err", cyc, d), 32'(err_w[d]), 32'(m_err[d]));
`endif
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_wren = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(negedge clk);
    ld_wren = 1'b0;
  endtask

  // Count 3-wait-state responses over n cycles, keeping the last word seen.
  task automatic watch3(input int n, output int seen, output logic [31:0] got);
    seen = 0;
    got  = 32'h0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rvalid_w[1]) begin
        seen++;
        got = rdata_w[1];
      end
    end
  endtask

  // Zero-wait fetch with rden held two cycles; samples the response cycle.
  task automatic u0_fetch(input logic [31:0] a, output logic rv, output logic [31:0] rd,
                          output logic err);
    @(negedge clk);
    rden = 1'b1;
    addr = a;
    @(posedge clk);
    #1;
    rv  = rvalid_w[0];
    rd  = rdata_w[0];
`ifdef IMEM_RESPONDER_ALIGN_CHECK_EN
    err = err_w[0];
`else
    err = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    rden = 1'b0;
    idle(6);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end, got running expected finished");
    $fatal(1);
  end

  initial begin
    int          seen;
    int          busy_cnt;
    int          rv_at;
    logic [31:0] got;
    logic        rv;
    logic        err;

    reset   = 1'b1;
    rden    = 1'b0;
    addr    = 32'h0;
    ld_wren = 1'b0;
    ld_addr = 32'h0;
    ld_data = 32'h0;
    idle(2);
    check("reset_rdata", rdata_w[0], 32'h0);
    check("reset_rvalid", 32'(rvalid_w[0]), 32'h0);
    check("reset_busy3", 32'(busy_w[1]), 32'h0);
    reset  = 1'b0;
    chk_en = 1'b1;

    load(32'h10, 32'h8C220004);
    load(32'h00, 32'h12345678);
    load(32'h20, 32'h11112222);
    load(32'h30, 32'h33334444);
    load(32'h40, 32'h55556666);

    // Zero-wait fetch: response the cycle after the request edge, one pulse.
    @(negedge clk);
    rden = 1'b1;
    addr = 32'h10;
    @(posedge clk);
    #1;
    check("t1_rvalid", 32'(rvalid_w[0]), 32'h1);
    check("t1_rdata", rdata_w[0], 32'h8C220004);
    @(negedge clk);
    @(posedge clk);
    #1;
    check("t1_single_pulse", 32'(rvalid_w[0]), 32'h0);
    @(negedge clk);
    rden = 1'b0;
    idle(8);

    // Three wait states: busy for 4 cycles, rvalid in the 4th, data held.
    @(negedge clk);
    rden     = 1'b1;
    addr     = 32'h0;
    busy_cnt = 0;
    rv_at    = -1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      busy_cnt += int'(busy_w[1]);
      if (rvalid_w[1]) rv_at = i;
      @(negedge clk);
      if (i == 2) rden = 1'b0;
    end
    check("t2_busy_cycles", 32'(busy_cnt), 32'd4);
    check("t2_rvalid_cycle", 32'(rv_at), 32'd4);
    check("t2_rdata_held", rdata_w[1], 32'h12345678);

    // Second rising edge during WAIT is dropped.
    @(negedge clk);
    rden = 1'b1;
    addr = 32'h20;
    @(negedge clk);
    rden = 1'b0;
    @(negedge clk);
    rden = 1'b1;
    addr = 32'h30;
    @(negedge clk);
    rden = 1'b0;
    watch3(10, seen, got);
    check("t3_one_response", 32'(seen), 32'd1);
    check("t3_rdata", got, 32'h11112222);

    // Load write during WAIT is visible in the response.
    @(negedge clk);
    rden = 1'b1;
    addr = 32'h40;
    @(negedge clk);
    ld_wren = 1'b1;
    ld_addr = 32'h40;
    ld_data = 32'hDEADBEEF;
    @(negedge clk);
    ld_wren = 1'b0;
    rden    = 1'b0;
    watch3(6, seen, got);
    check("t4_one_response", 32'(seen), 32'd1);
    check("t4_new_data", got, 32'hDEADBEEF);

    // Load write on the edge entering RESP returns the old word.
    @(negedge clk);
    rden = 1'b1;
    addr = 32'h20;
    @(negedge clk);
    @(negedge clk);
    rden = 1'b0;
    @(negedge clk);
    ld_wren = 1'b1;
    ld_addr = 32'h20;
    ld_data = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    check("t5_rvalid", 32'(rvalid_w[1]), 32'h1);
    check("t5_old_data", rdata_w[1], 32'h11112222);
    @(negedge clk);
    ld_wren = 1'b0;
    idle(4);
    u0_fetch(32'h20, rv, got, err);
    check("t5_write_landed", got, 32'hCAFEF00D);

    // Reset during WAIT aborts the fetch.
    @(negedge clk);
    rden = 1'b1;
    addr = 32'h0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rden = 1'b0;
    @(posedge clk);
    #1;
    check("t6_busy_before", 32'(busy_w[1]), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6_busy_rst", 32'(busy_w[1]), 32'h0);
    check("t6_rvalid_rst", 32'(rvalid_w[1]), 32'h0);
    check("t6_rdata_rst", rdata_w[1], 32'h0);
    @(negedge clk);
    reset = 1'b0;
    watch3(8, seen, got);
    check("t6_no_response", 32'(seen), 32'd0);
    @(negedge clk);
    rden = 1'b1;
    addr = 32'h10;
    @(negedge clk);
    @(negedge clk);
    rden = 1'b0;
    watch3(6, seen, got);
    check("t6_rereq_count", 32'(seen), 32'd1);
    check("t6_rereq_data", got, 32'h8C220004);

    // Address wraps modulo the array size.
    u0_fetch(32'h1010, rv, got, err);
    check("t7_wrap_rvalid", 32'(rv), 32'h1);
    check("t7_wrap_data", got, 32'h8C220004);

    // Misaligned fetch and misaligned load write.
    u0_fetch(32'h12, rv, got, err);
    check("t8_rvalid", 32'(rv), 32'h1);
`ifdef IMEM_RESPONDER_ALIGN_CHECK_EN
    check("t8_err", 32'(err), 32'h1);
    check("t8_rdata_zero", got, 32'h0);
`else
    check("t8_rdata_word4", got, 32'h8C220004);
`endif
    load(32'h13, 32'hBAD00BAD);
    u0_fetch(32'h10, rv, got, err);
`ifdef IMEM_RESPONDER_ALIGN_CHECK_EN
    check("t9_write_dropped", got, 32'h8C220004);
`else
    check("t9_write_lands", got, 32'hBAD00BAD);
`endif

    idle(4);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
